// File: rtl/mcp3008_responder.sv
// mcp3008_responder: SPI target that mimics an MCP3008 8-channel 10-bit ADC.
// Samples sclk/cs_n/din through synchronizers, decodes the start bit and the
// {SGL,D2,D1,D0} command, and shifts the selected (or differential, clamped)
// sample out MSB first on sclk falling edges.
// Optional build macro MCP3008_LSB_REPEAT_EN adds the LSB-first repeat phase
// that follows B0; without it dout returns to 0 after B0.
module mcp3008_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int ADC_BITS    = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  din,
    output logic                  dout,
    output logic                  dout_oe,
    input  logic [8*ADC_BITS-1:0] ch_data,
    output logic [3:0]            ch_sel,
    output logic                  conv_done
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        CMD,
        SAMPLE,
        OUT_MSB,
        OUT_LSB,
        DONE
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(ADC_BITS - 1);

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, din_sync, flush;
    logic                   sclk_d, cs_d, armed;
    logic                   sclk_s, cs_s, din_s, flushed;
    logic                   sclk_rise, sclk_fall, cs_fall;

    state_t                 state, state_nx;
    logic [3:0]             cnt, cnt_nx;
    logic [2:0]             cmd_sh, cmd_nx;
    logic [3:0]             cmd_full;
    logic [ADC_BITS-1:0]    hold, hold_nx;
    logic [ADC_BITS-1:0]    sel_value;
    logic [ADC_BITS:0]      diff;
    logic [ADC_BITS-1:0]    ch [8];
    logic                   dout_nx, oe_nx, done_nx;
    logic [3:0]             chsel_nx;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign din_s     = din_sync[SYNC_STAGES-1];
    assign flushed   = flush[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    // A falling cs_n only counts once cs_n has been seen high after reset;
    // the preset-high synchronizer would otherwise fake a fall when reset is
    // released while the initiator still holds cs_n low.
    assign cs_fall   = cs_d & ~cs_s & armed;
    assign cmd_full  = {cmd_sh, din_s};

    // Input synchronizers, edge-detect registers and post-reset arming
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            din_sync  <= '0;
            flush     <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            din_sync  <= {din_sync[SYNC_STAGES-2:0], din};
            flush     <= {flush[SYNC_STAGES-2:0], 1'b1};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
            armed     <= armed | (flushed & cs_s);
        end
    end

    // Channel selection: single-ended pick or clamped differential pair
    always_comb begin
        for (int unsigned i = 0; i < 8; i++) begin
            ch[i] = ch_data[i*ADC_BITS +: ADC_BITS];
        end
        diff      = '0;
        sel_value = '0;
        if (cmd_full[3]) begin
            sel_value = ch[cmd_full[2:0]];
        end else begin
            if (cmd_full[0]) begin
                diff = {1'b0, ch[{cmd_full[2:1], 1'b1}]} - {1'b0, ch[{cmd_full[2:1], 1'b0}]};
            end else begin
                diff = {1'b0, ch[{cmd_full[2:1], 1'b0}]} - {1'b0, ch[{cmd_full[2:1], 1'b1}]};
            end
            sel_value = diff[ADC_BITS] ? '0 : diff[ADC_BITS-1:0];
        end
    end

    // Frame FSM: next state and next output/datapath values
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        cmd_nx   = cmd_sh;
        hold_nx  = hold;
        dout_nx  = dout;
        oe_nx    = dout_oe;
        chsel_nx = ch_sel;
        done_nx  = 1'b0;
        if (cs_s) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            dout_nx  = 1'b0;
            oe_nx    = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state_nx = WAIT_START;
                        cnt_nx   = '0;
                    end
                end
                WAIT_START: begin
                    if (sclk_rise && din_s) begin
                        state_nx = CMD;
                        cnt_nx   = '0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        cmd_nx = cmd_full[2:0];
                        if (cnt == 4'd3) begin
                            chsel_nx = cmd_full;
                            hold_nx  = sel_value;
                            state_nx = SAMPLE;
                            cnt_nx   = '0;
                        end else begin
                            cnt_nx = cnt + 4'd1;
                        end
                    end
                end
                SAMPLE: begin
                    if (sclk_fall) begin
                        oe_nx    = 1'b1;
                        dout_nx  = 1'b0;
                        state_nx = OUT_MSB;
                        cnt_nx   = '0;
                    end
                end
                OUT_MSB: begin
                    if (sclk_fall) begin
                        dout_nx = hold[LAST_BIT - cnt];
                        if (cnt == LAST_BIT) begin
                            done_nx = 1'b1;
                            cnt_nx  = '0;
`ifdef MCP3008_LSB_REPEAT_EN
                            state_nx = OUT_LSB;
`else
                            state_nx = DONE;
`endif
                        end else begin
                            cnt_nx = cnt + 4'd1;
                        end
                    end
                end
                OUT_LSB: begin
                    if (sclk_fall) begin
                        dout_nx = hold[cnt + 4'd1];
                        if (cnt == LAST_BIT - 4'd1) begin
                            state_nx = DONE;
                            cnt_nx   = '0;
                        end else begin
                            cnt_nx = cnt + 4'd1;
                        end
                    end
                end
                // B0 (or B9) holds until the next fall, then the line idles low
                DONE: begin
                    if (sclk_fall) begin
                        dout_nx = 1'b0;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cmd_sh    <= '0;
            hold      <= '0;
            dout      <= 1'b0;
            dout_oe   <= 1'b0;
            ch_sel    <= '0;
            conv_done <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            cmd_sh    <= cmd_nx;
            hold      <= hold_nx;
            dout      <= dout_nx;
            dout_oe   <= oe_nx;
            ch_sel    <= chsel_nx;
            conv_done <= done_nx;
        end
    end

endmodule

// File: tb/tb_mcp3008_responder.sv
// tb_mcp3008_responder: self-checking bench for mcp3008_responder.
// Table vectors, randomized frames against a behavioural ADC model, and
// hand sequences for abort, simultaneous edges and mid-frame reset.
// Honours MCP3008_LSB_REPEAT_EN for the expected bit stream.
`timescale 1ns/1ps
module tb_mcp3008_responder;

    localparam int SYNC  = 2;
    localparam int HALF  = 8;   // clk cycles per sclk half period
    localparam int NREAD = 22;  // null + 10 MSB + 9 LSB + 2 idle
`ifdef MCP3008_LSB_REPEAT_EN
    localparam bit LSB_EN = 1'b1;
`else
    localparam bit LSB_EN = 1'b0;
`endif

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        sclk    = 1'b0;
    logic        cs_n    = 1'b1;
    logic        din     = 1'b0;
    logic [79:0] ch_data = '0;
    logic        dout, dout_oe, conv_done;
    logic [3:0]  ch_sel;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;

    typedef struct {
        int          lead;
        logic [3:0]  cmd;
        logic [79:0] ch;
        logic [9:0]  exp_val;
        logic [3:0]  exp_sel;
    } vec_t;

    vec_t tbl[7];

    mcp3008_responder #(.SYNC_STAGES(SYNC), .ADC_BITS(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .din       (din),
        .dout      (dout),
        .dout_oe   (dout_oe),
        .ch_data   (ch_data),
        .ch_sel    (ch_sel),
        .conv_done (conv_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (conv_done === 1'b1) done_cnt++;
    end

    function automatic logic [79:0] mk(input logic [9:0] c7, input logic [9:0] c6,
                                       input logic [9:0] c5, input logic [9:0] c4,
                                       input logic [9:0] c3, input logic [9:0] c2,
                                       input logic [9:0] c1, input logic [9:0] c0);
        return {c7, c6, c5, c4, c3, c2, c1, c0};
    endfunction

    function automatic logic [79:0] rand_ch();
        logic [79:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i*10 +: 10] = 10'($urandom_range(0, 1023));
        return r;
    endfunction

    // What an MCP3008 would report for this command and these inputs
    function automatic logic [9:0] model(input logic [79:0] ch, input logic [3:0] c);
        int v[8];
        int r;
        int lo;
        for (int i = 0; i < 8; i++) v[i] = int'(ch[i*10 +: 10]);
        if (c[3]) begin
            r = v[int'(c[2:0])];
        end else begin
            lo = 2 * int'(c[2:1]);
            r  = c[0] ? (v[lo+1] - v[lo]) : (v[lo] - v[lo+1]);
            if (r < 0) r = 0;
        end
        return r[9:0];
    endfunction

    // Bits seen by the initiator on successive rising edges after D0
    function automatic logic [31:0] exp_stream(input logic [9:0] v, input int nread);
        logic [31:0] s;
        logic        b;
        s = '0;
        for (int k = 0; k < nread; k++) begin
            if (k == 0)                    b = 1'b0;
            else if (k <= 10)              b = v[10 - k];
            else if (LSB_EN && k <= 19)    b = v[k - 10];
            else                           b = 1'b0;
            s = {s[30:0], b};
        end
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic sclk_cycle(input logic bit_in, output logic d_s, output logic oe_s);
        din = bit_in;
        repeat (HALF) @(negedge clk);
        d_s  = dout;
        oe_s = dout_oe;
        sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic run_frame(input int lead, input logic [3:0] cmd, input int nread,
                             input bit scramble, output logic [31:0] rd,
                             output logic [31:0] oe_tr);
        logic d, o;
        rd    = '0;
        oe_tr = '0;
        cs_n  = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < lead; i++) begin
            sclk_cycle(1'b0, d, o);
            oe_tr = {oe_tr[30:0], o};
        end
        sclk_cycle(1'b1, d, o);
        oe_tr = {oe_tr[30:0], o};
        for (int i = 3; i >= 0; i--) begin
            sclk_cycle(cmd[i], d, o);
            oe_tr = {oe_tr[30:0], o};
        end
        if (scramble) ch_data = rand_ch();
        for (int k = 0; k < nread; k++) begin
            sclk_cycle(1'b0, d, o);
            rd    = {rd[30:0], d};
            oe_tr = {oe_tr[30:0], o};
        end
        cs_n = 1'b1;
        din  = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input int lead, input logic [3:0] cmd,
                               input logic [79:0] ch, input logic [9:0] ev,
                               input logic [3:0] esel, input bit scramble);
        logic [31:0] rd, oe_tr;
        int d0;
        ch_data = ch;
        d0      = done_cnt;
        run_frame(lead, cmd, NREAD, scramble, rd, oe_tr);
        chk({tag, " stream"}, rd, exp_stream(ev, NREAD));
        chk({tag, " dout_oe"}, oe_tr, (32'h1 << NREAD) - 32'h1);
        chk({tag, " ch_sel"}, 32'(ch_sel), 32'(esel));
        chk({tag, " conv_done"}, 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        logic        d, o, o_acc;
        logic [79:0] rch;
        logic [3:0]  rc;
        int          rlead, n, d0;

        tbl[0] = '{0, 4'b1101, mk(10'h011, 10'h022, 10'h2A5, 10'h044, 10'h055, 10'h066, 10'h077, 10'h088), 10'h2A5, 4'hD};
        tbl[1] = '{0, 4'b0010, mk(10'd5, 10'd6, 10'd7, 10'd8, 10'd300, 10'd700, 10'd9, 10'd10), 10'h190, 4'h2};
        tbl[2] = '{0, 4'b0011, mk(10'd5, 10'd6, 10'd7, 10'd8, 10'd300, 10'd700, 10'd9, 10'd10), 10'h000, 4'h3};
        tbl[3] = '{3, 4'b1111, mk(10'h001, 10'h3FE, 10'h3FD, 10'h3FC, 10'h3FB, 10'h3FA, 10'h3F9, 10'h3F8), 10'h001, 4'hF};
        tbl[4] = '{0, 4'b1001, mk(10'h100, 10'h0FF, 10'h155, 10'h2AA, 10'h333, 10'h0CC, 10'h301, 10'h123), 10'h301, 4'h9};
        tbl[5] = '{1, 4'b1000, mk(10'h000, 10'h001, 10'h002, 10'h003, 10'h004, 10'h005, 10'h006, 10'h3FF), 10'h3FF, 4'h8};
        tbl[6] = '{0, 4'b0111, mk(10'd1023, 10'd100, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6), 10'd923, 4'h7};

        // Reset values
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset dout", 32'(dout), 32'd0);
        chk("reset dout_oe", 32'(dout_oe), 32'd0);
        chk("reset ch_sel", 32'(ch_sel), 32'd0);
        chk("reset conv_done", 32'(conv_done), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Table vectors
        for (int i = 0; i < 7; i++) begin
            check_frame($sformatf("vec%0d", i), tbl[i].lead, tbl[i].cmd, tbl[i].ch,
                        tbl[i].exp_val, tbl[i].exp_sel, 1'b0);
        end

        // Randomized frames; ch_data is rescrambled after capture
        for (int i = 0; i < 20; i++) begin
            rch   = rand_ch();
            rc    = 4'($urandom_range(0, 15));
            rlead = $urandom_range(0, 3);
            check_frame($sformatf("rand%0d", i), rlead, rc, rch, model(rch, rc), rc, 1'b1);
        end

        // Abort after 4 data bits, cs_n rising on the same instant as sclk falls
        ch_data = tbl[0].ch;
        d0      = done_cnt;
        cs_n    = 1'b0;
        repeat (HALF) @(negedge clk);
        sclk_cycle(1'b1, d, o);
        for (int i = 3; i >= 0; i--) sclk_cycle(tbl[0].cmd[i], d, o);
        for (int k = 0; k < 5; k++) sclk_cycle(1'b0, d, o);
        cs_n = 1'b1;
        n    = 0;
        while (dout_oe !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dout_oe !== 1'b0 || n > SYNC + 2) begin
            errors++;
            $display("FAIL abort dout_oe latency: got %0d clk (oe=%b), required <= %0d clk", n, dout_oe, SYNC + 2);
        end
        chk("abort dout", 32'(dout), 32'd0);
        repeat (HALF) @(negedge clk);
        chk("abort conv_done", 32'(done_cnt - d0), 32'd0);
        check_frame("after abort", 0, 4'b1000, tbl[5].ch, 10'h3FF, 4'h8, 1'b0);

        // Reset mid OUT_MSB, released with cs_n still low
        ch_data = tbl[0].ch;
        cs_n    = 1'b0;
        repeat (HALF) @(negedge clk);
        sclk_cycle(1'b1, d, o);
        for (int i = 3; i >= 0; i--) sclk_cycle(tbl[0].cmd[i], d, o);
        for (int k = 0; k < 4; k++) sclk_cycle(1'b0, d, o);
        chk("pre-reset dout_oe", 32'(dout_oe), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("async reset dout_oe", 32'(dout_oe), 32'd0);
        chk("async reset ch_sel", 32'(ch_sel), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        d0    = done_cnt;
        o_acc = 1'b0;
        sclk_cycle(1'b1, d, o);
        o_acc = o_acc | o;
        for (int k = 0; k < 24; k++) begin
            sclk_cycle(1'($urandom_range(0, 1)), d, o);
            o_acc = o_acc | o;
        end
        chk("post-reset no frame dout_oe", 32'(o_acc | dout_oe), 32'd0);
        chk("post-reset no frame conv_done", 32'(done_cnt - d0), 32'd0);
        cs_n = 1'b1;
        din  = 1'b0;
        repeat (HALF) @(negedge clk);
        check_frame("after reset", 0, tbl[0].cmd, tbl[0].ch, 10'h2A5, 4'hD, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
